truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have one parameter, SETTLE_CYCLES, default 4, giving the cycles each minterm is driven before res is sampled; legal range 3..15.
REQ-002 Port clk, input, 1 bit: the single clock, rising-edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: one-cycle request to begin a sweep.
REQ-005 Port expected, input, 16 bits: expected truth table; bit i is f(i).
REQ-006 Port res, input, 1 bit: function output returned from the 8:1-mux stage under test.
REQ-007 Ports x, y, z, w, outputs, 1 bit each: minterm index drive; x is index bit 3 and w is index bit 0.
REQ-008 Port g, output, 1 bit: active-low strobe to the mux stage.
REQ-009 Port busy, output, 1 bit: a sweep is in progress.
REQ-010 Port done, output, 1 bit: a sweep has completed.
REQ-011 Port pass, output, 1 bit: the completed sweep had no mismatch.
REQ-012 Port captured, output, 16 bits: sampled res values, bit i holds the sample for minterm i.
REQ-013 Port fail_idx, output, 4 bits: lowest mismatching minterm index.
REQ-014 Port fail_valid, output, 1 bit: at least one mismatch has been seen.

Function
REQ-015 The FSM SHALL have the states IDLE, DRIVE, SAMPLE and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL, on that edge: register expected, clear captured, pass, fail_idx and fail_valid, set the index to 0, and enter DRIVE.
REQ-017 In DRIVE, x/y/z/w SHALL equal the index, g SHALL be 0, and a settle counter SHALL run for SETTLE_CYCLES cycles before the FSM enters SAMPLE.
REQ-018 In SAMPLE (one cycle), the synchronized res SHALL be written to captured[index] and compared with expected[index].
REQ-019 On the first mismatch of a sweep, fail_idx SHALL take the index and fail_valid SHALL be set; later mismatches SHALL NOT change fail_idx.
REQ-020 From SAMPLE, the FSM SHALL enter DONE at index 15 and otherwise increment the index and re-enter DRIVE.
REQ-021 A full sweep SHALL take exactly 16*(SETTLE_CYCLES+1) cycles from the start edge to the first cycle of done=1.
REQ-022 In DONE, done SHALL be 1, pass SHALL equal ~fail_valid, and all results SHALL hold until the next start or rst.
REQ-023 In IDLE and DONE, g SHALL be 1, and x/y/z/w SHALL hold their last value (0 after reset).
REQ-024 busy SHALL be 1 exactly in DRIVE and SAMPLE.
REQ-025 start SHALL be ignored while busy=1, and changes on expected mid-sweep SHALL have no effect.
REQ-026 res SHALL pass through a 2-flop synchronizer before sampling, so the minimum SETTLE_CYCLES of 3 covers 2 sync cycles plus 1 propagation cycle.

Reset
REQ-027 While rst=1, the block SHALL enter IDLE asynchronously, at any point including mid-sweep, with these output values: x=y=z=w=0, g=1, busy=0, done=0, pass=0, captured=0, fail_idx=0, fail_valid=0; the synchronizer and settle counter SHALL also clear.
REQ-028 After rst deasserts, the block SHALL remain in IDLE until start=1.

Configuration
REQ-029 With SWEEPER_STOP_ON_FAIL_EN defined, a mismatch in SAMPLE SHALL send the FSM to DONE immediately, leaving captured bits above fail_idx at 0.
REQ-030 Without SWEEPER_STOP_ON_FAIL_EN, the sweep SHALL always cover all 16 minterms.

Structure
REQ-031 Package truth_table_sweeper_pkg SHALL hold the state enum (sweep_state_t), N_MINTERMS=16 and IDX_W=4.
REQ-032 The synchronizer SHALL be a sub-module named sync2 (1-bit, async active-high reset, output 0 in reset).

Verification
REQ-033 Ideal f model (minterms 2,5,7,9,12,13), expected=16'h32A4, SETTLE_CYCLES=4, start pulse -> done after 80 cycles, pass=1, captured=16'h32A4, fail_valid=0.
REQ-034 res tied 0, expected=16'h32A4, macro undefined -> done after 80 cycles, pass=0, fail_idx=2, fail_valid=1, captured=16'h0000.
REQ-035 Same stimulus as REQ-034, macro defined -> done after 15 cycles, fail_idx=2, captured=16'h0000, x/y/z/w=4'b0010.
REQ-036 rst pulsed while index=7 in DRIVE -> all outputs at their reset values before the next clk edge; a following start gives a clean full sweep.
REQ-037 start pulses and an expected change to 16'hFFFF at index 5 -> no restart, and the results match REQ-033.
REQ-038 res tied 1, expected=16'hFFFF -> pass=1, captured=16'hFFFF; g observed 0 only while busy=1.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_table_sweeper_pkg;

    localparam int N_MINTERMS = 16;
    localparam int IDX_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(N_MINTERMS - 1);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_sync2.sv
// Two-flop synchronizer for the returned function output; clears to 0 in reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 minterms into a mux stage and compares the returned value with an expected table.
// Optional build macro SWEEPER_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
//
//   state  | meaning
//   IDLE   | waiting for start after reset, g high
//   DRIVE  | minterm index driven, g low, settle counter running
//   SAMPLE | synchronized res captured and compared for one cycle
//   DONE   | results held, done high, waiting for the next start
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_MINTERMS-1:0] expected,
    input  logic                  res,
    output logic                  x,
    output logic                  y,
    output logic                  z,
    output logic                  w,
    output logic                  g,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_MINTERMS-1:0] captured,
    output logic [IDX_W-1:0]      fail_idx,
    output logic                  fail_valid
);

    // Counter reloads to SETTLE_CYCLES-1 so the terminal count lands on the last DRIVE cycle.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    sweep_state_t          r_state;
    sweep_state_t          w_state_next;
    logic [IDX_W-1:0]      r_idx;
    logic [3:0]            r_settle;
    logic [N_MINTERMS-1:0] r_expected;
    logic [N_MINTERMS-1:0] r_captured;
    logic [IDX_W-1:0]      r_fail_idx;
    logic                  r_fail_valid;
    logic                  w_res_s;
    logic                  w_settled;
    logic                  w_mismatch;
    logic                  w_last;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .i_d (res),
        .o_q (w_res_s)
    );

    assign w_settled  = (r_settle == 4'd0);
    assign w_last     = is_last_idx(r_idx);
    assign w_mismatch = (r_state == SAMPLE) && (w_res_s != r_expected[r_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (w_settled) begin
                    w_state_next = SAMPLE;
                end
            end
            SAMPLE: begin
`ifdef SWEEPER_STOP_ON_FAIL_EN
                if (w_last || w_mismatch) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = DRIVE;
                end
`else
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = DRIVE;
                end
`endif
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_settle     <= '0;
            r_expected   <= '0;
            r_captured   <= '0;
            r_fail_idx   <= '0;
            r_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_expected   <= expected;
                        r_captured   <= '0;
                        r_fail_idx   <= '0;
                        r_fail_valid <= 1'b0;
                        r_idx        <= '0;
                        r_settle     <= SETTLE_LOAD;
                    end
                end
                DRIVE: begin
                    if (!w_settled) begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                SAMPLE: begin
                    r_captured[r_idx] <= w_res_s;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_idx   <= r_idx;
                        r_fail_valid <= 1'b1;
                    end
                    if (w_state_next == DRIVE) begin
                        r_idx    <= r_idx + 1'b1;
                        r_settle <= SETTLE_LOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode straight from registers so reset reaches them without a clock edge.
    assign {x, y, z, w} = r_idx;
    assign busy         = (r_state == DRIVE) || (r_state == SAMPLE);
    assign g            = ~busy;
    assign done         = (r_state == DONE);
    assign pass         = done && !r_fail_valid;
    assign captured     = r_captured;
    assign fail_idx     = r_fail_idx;
    assign fail_valid   = r_fail_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: a gated mux model returns f(index) and a reference model predicts each sweep.
module tb_truth_table_sweeper;

    localparam int S = 4;
    localparam int L = 16 * (S + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] expected = 16'h0000;
    logic        res;
    logic        x, y, z, w, g, busy, done, pass, fail_valid;
    logic [15:0] captured;
    logic [3:0]  fail_idx;

    logic [15:0] f_tb = 16'h0000;
    logic [3:0]  w_idx;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;

    typedef struct {
        logic [15:0] cap;
        logic [3:0]  fi;
        logic        fv;
        logic        ps;
        int          lat;
        logic [3:0]  xyzw;
        int          t0;
    } exp_t;

    exp_t q[$];

    truth_table_sweeper #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .expected   (expected),
        .res        (res),
        .x          (x),
        .y          (y),
        .z          (z),
        .w          (w),
        .g          (g),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .captured   (captured),
        .fail_idx   (fail_idx),
        .fail_valid (fail_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign w_idx = {x, y, z, w};
    assign res   = g ? 1'b0 : f_tb[w_idx];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: captured is the true function, first differing bit is the failure.
    function automatic exp_t model(input logic [15:0] f, input logic [15:0] e);
        exp_t m;
        m.fv = 1'b0;
        m.fi = 4'd0;
        m.cap = f;
        for (int i = 0; i < 16; i++) begin
            if (f[i] != e[i] && !m.fv) begin
                m.fv = 1'b1;
                m.fi = 4'(i);
            end
        end
        m.ps = !m.fv;
        m.lat = L;
        m.xyzw = 4'hF;
`ifdef SWEEPER_STOP_ON_FAIL_EN
        if (m.fv) begin
            for (int i = 0; i < 16; i++) begin
                if (i > int'(m.fi)) m.cap[i] = 1'b0;
            end
            m.lat = (int'(m.fi) + 1) * (S + 1);
            m.xyzw = m.fi;
        end
`endif
        m.t0 = 0;
        return m;
    endfunction

    // Monitor: pops the scoreboard on each rising done.
    exp_t mon_e;
    int   busy_cnt = 0;
    bit   g_bad = 1'b0;
    bit   prev_done = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            g_bad = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (!g && !busy) g_bad = 1'b1;
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: done rose with empty scoreboard");
                end else begin
                    mon_e = q.pop_front();
                    check("captured", captured, mon_e.cap);
                    check("fail_idx", fail_idx, mon_e.fi);
                    check("fail_valid", fail_valid, mon_e.fv);
                    check("pass", pass, mon_e.ps);
                    check("xyzw_at_done", w_idx, mon_e.xyzw);
                    check("latency", cyc - mon_e.t0 - 1, mon_e.lat);
                    check("busy_cycles", busy_cnt, mon_e.lat);
                    check("g_low_only_busy", g_bad, 0);
                end
                busy_cnt = 0;
                g_bad = 1'b0;
            end
            prev_done = done;
        end
    end

    task automatic pulse_start(input logic [15:0] f, input logic [15:0] e, output exp_t m);
        @(negedge clk);
        f_tb = f;
        expected = e;
        m = model(f, e);
        m.t0 = cyc;
        q.push_back(m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input exp_t m);
        bit got = 1'b0;
        for (int k = 0; k < L + 20 && !got; k++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", tag, L + 20);
            q.delete();
        end else begin
            repeat (3) @(negedge clk);
            check({tag, "_hold_done"}, done, 1);
            check({tag, "_hold_captured"}, captured, m.cap);
        end
    endtask

    task automatic run_sweep(input logic [15:0] f, input logic [15:0] e, input string tag);
        exp_t m;
        pulse_start(f, e, m);
        wait_done(tag, m);
    endtask

    task automatic wait_idx(input logic [3:0] target, input string tag, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < L + 20 && !ok; k++) begin
            if (busy && w_idx == target) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_wait_idx: index %0d not reached", tag, target);
        end
    endtask

    initial begin
        exp_t m;
        bit   ok;
        logic [15:0] f, e;

        repeat (3) @(negedge clk);
        check("rst_xyzw", w_idx, 0);
        check("rst_g", g, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_captured", captured, 0);
        check("rst_fail_idx", fail_idx, 0);
        check("rst_fail_valid", fail_valid, 0);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        run_sweep(16'h32A4, 16'h32A4, "ideal");
        run_sweep(16'h0000, 16'h32A4, "res0");
        run_sweep(16'hFFFF, 16'hFFFF, "res1");

        // Asynchronous reset in the middle of minterm 7.
        pulse_start(16'h32A4, 16'h32A4, m);
        wait_idx(4'd7, "midrst", ok);
        #2 rst = 1'b1;
        #1;
        check("midrst_xyzw", w_idx, 0);
        check("midrst_g", g, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_pass", pass, 0);
        check("midrst_captured", captured, 0);
        check("midrst_fail_idx", fail_idx, 0);
        check("midrst_fail_valid", fail_valid, 0);
        q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        run_sweep(16'h32A4, 16'h32A4, "post_rst");

        // Restart attempts and expected change mid-sweep must not disturb the sweep.
        pulse_start(16'h32A4, 16'h32A4, m);
        wait_idx(4'd5, "nochange", ok);
        expected = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("nochange", m);

        for (int n = 0; n < 8; n++) begin
            f = 16'($urandom);
            case ($urandom_range(0, 2))
                0: e = f;
                1: e = f ^ (16'h0001 << $urandom_range(0, 15));
                default: e = 16'($urandom);
            endcase
            run_sweep(f, e, "random");
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
